// File: rtl/ecc_apb_ctrl_if.sv
// ----------------------------------------------------------------------------
// ecc_apb_ctrl_if
// APB bus bundle shared by the ECC controller and whatever drives it.
//   PADDR   : address, only the low nibble is decoded by the controller
//   PWDATA  : write data
//   PSEL    : slave select
//   PENABLE : access phase
//   PWRITE  : 1 = write, 0 = read
//   PRDATA  : read data returned by the slave
// master modport drives the request side, slave modport returns PRDATA.
// ----------------------------------------------------------------------------
interface ecc_apb_ctrl_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PRDATA;

  modport master (
    output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  PRDATA
  );

  modport slave (
    input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output PRDATA
  );
endinterface

// File: rtl/ecc_apb_ctrl.sv
// ----------------------------------------------------------------------------
// ecc_apb_ctrl
// APB register file and one-shot operation sequencer for the ECC core.
// Software loads DATA_IN / CODEWORD_WIDTH / NOISE, then writes CTRL to launch.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   apb                 : APB slave (ecc_apb_ctrl_if.slave), PRDATA combinational
//   core_start          : one-cycle launch pulse to the core
//   core_ctrl/data_in/width/noise : operand copies latched at launch
//   core_valid, core_data_out, core_num_of_errors : core result
//   data_out, num_of_errors : published result (3 errors = timeout)
//   operation_done      : one-cycle completion pulse
// Register map (PADDR[3:0]): 0x0 CTRL, 0x4 DATA_IN, 0x8 CODEWORD_WIDTH, 0xC NOISE
// ----------------------------------------------------------------------------
module ecc_apb_ctrl #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_ctrl_if.slave         apb,
  output logic                  core_start,
  output logic [1:0]            core_ctrl,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [1:0]            core_width,
  output logic [DATA_WIDTH-1:0] core_noise,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_num_of_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     wait_cnt;
  logic [AMBA_WORD-1:0] ctrl_reg, data_in_reg, width_reg, noise_reg;
  logic [3:0]           addr;
  logic                 wr_en, rd_en, ctrl_wr;
  logic                 launch, capture, timed_out;
  logic                 unused_paddr_hi;

  assign addr    = apb.PADDR[3:0];
  assign wr_en   = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en   = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  // CTRL is only writable while idle so a running operation cannot be relaunched.
  assign ctrl_wr = wr_en && (addr == 4'h0) && (state == S_IDLE);

  // Upper address bits are deliberately not decoded.
  assign unused_paddr_hi = ^apb.PADDR[AMBA_ADDR_WIDTH-1:4];

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg    <= '0;
      data_in_reg <= '0;
      width_reg   <= '0;
      noise_reg   <= '0;
    end else begin
      if (ctrl_wr)                      ctrl_reg    <= apb.PWDATA;
      if (wr_en && (addr == 4'h4))      data_in_reg <= apb.PWDATA;
      if (wr_en && (addr == 4'h8))      width_reg   <= apb.PWDATA;
      if (wr_en && (addr == 4'hC))      noise_reg   <= apb.PWDATA;
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (rd_en) begin
      case (addr)
        4'h0:    apb.PRDATA = ctrl_reg;
        4'h4:    apb.PRDATA = data_in_reg;
        4'h8:    apb.PRDATA = width_reg;
        4'hC:    apb.PRDATA = noise_reg;
        default: apb.PRDATA = '0;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // core_valid is checked before the timeout so a result on the last
  // allowed cycle is still published.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE:  if (ctrl_wr) state_next = S_START;
      S_START: begin
        launch     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Counts cycles spent in WAIT; cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst || (state != S_WAIT)) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end

  // Core handshake and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      core_start     <= 1'b0;
      core_ctrl      <= '0;
      core_data_in   <= '0;
      core_width     <= '0;
      core_noise     <= '0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
    end else begin
      core_start     <= launch;
      operation_done <= (state == S_DONE);
      if (launch) begin
        core_ctrl    <= ctrl_reg[1:0];
        core_data_in <= data_in_reg[DATA_WIDTH-1:0];
        core_width   <= width_reg[1:0];
        core_noise   <= noise_reg[DATA_WIDTH-1:0];
      end
      if (capture) begin
        data_out      <= core_data_out;
        num_of_errors <= core_num_of_errors;
      end else if (timed_out) begin
        num_of_errors <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
module tb_ecc_apb_ctrl;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_start;
  logic [1:0]    core_ctrl;
  logic [DW-1:0] core_data_in;
  logic [1:0]    core_width;
  logic [DW-1:0] core_noise;
  logic          core_valid;
  logic [DW-1:0] core_data_out;
  logic [1:0]    core_num_of_errors;
  logic [DW-1:0] data_out;
  logic          operation_done;
  logic [1:0]    num_of_errors;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ecc_apb_ctrl_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32)) apb ();

  ecc_apb_ctrl #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .apb                (apb.slave),
    .core_start         (core_start),
    .core_ctrl          (core_ctrl),
    .core_data_in       (core_data_in),
    .core_width         (core_width),
    .core_noise         (core_noise),
    .core_valid         (core_valid),
    .core_data_out      (core_data_out),
    .core_num_of_errors (core_num_of_errors),
    .data_out           (data_out),
    .operation_done     (operation_done),
    .num_of_errors      (num_of_errors)
  );

  always @(posedge clk) begin
    if (core_start)     start_cnt++;
    if (operation_done) done_cnt++;
  end

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = a; apb.PENABLE = 1'b0;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Waits for operation_done, counting negedges on top of cyc_in.
  task automatic wait_done(input int cyc_in, output int cyc_out, output bit got);
    cyc_out = cyc_in;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      core_valid = 1'b0;
      cyc_out++;
      if (operation_done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [AW-1:0] addrs [4];
    addrs = '{20'h0, 20'h4, 20'h8, 20'hC};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (data_out !== '0 || num_of_errors !== 2'd0 || operation_done !== 1'b0 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data_out=%h err=%0d done=%b start=%b, expected all 0",
               data_out, num_of_errors, operation_done, core_start);
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(addrs[i], rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_%h: got %h expected 00000000", addrs[i], rd);
      end
    end
  endtask

  task automatic test_encode();
    int cyc;
    bit got;
    apb_write(20'h4, 32'h0000_00A5);
    apb_write(20'h8, 32'h0);
    apb_write(20'h0, 32'h0);
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL encode_start_early: got %b expected 0", core_start);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1 || core_data_in !== 32'hA5 || core_ctrl !== 2'd0 || core_width !== 2'd0) begin
      errors++;
      $display("FAIL encode_launch: got start=%b data_in=%h ctrl=%0d width=%0d expected 1 000000a5 0 0",
               core_start, core_data_in, core_ctrl, core_width);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL encode_start_pulse: got %b expected 0", core_start);
    end
    core_valid = 1'b1; core_data_out = 32'h3A5; core_num_of_errors = 2'd0;
    wait_done(2, cyc, got);
    checks++;
    if (!got || cyc != 4) begin
      errors++;
      $display("FAIL encode_latency: got done=%0b after %0d cycles, expected done after 4", got, cyc);
    end
    checks++;
    if (data_out !== 32'h3A5 || num_of_errors !== 2'd0) begin
      errors++;
      $display("FAIL encode_result: got %h/%0d expected 000003a5/0", data_out, num_of_errors);
    end
    @(negedge clk);
    checks++;
    if (operation_done !== 1'b0) begin
      errors++;
      $display("FAIL encode_done_pulse: got %b expected 0", operation_done);
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    apb_write(20'hC, 32'hDEAD_BEEF);
    apb_read(20'hC, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_noise: got %h expected deadbeef", rd);
    end
    apb_read(20'h4, rd);
    checks++;
    if (rd !== 32'hA5) begin
      errors++;
      $display("FAIL read_data_in: got %h expected 000000a5", rd);
    end
    apb_read(20'h10, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL read_0x10: got %h expected 00000000", rd);
    end
    apb_read(20'h2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL read_unmapped: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_decode_busy();
    int cyc;
    bit got;
    int s0;
    logic [31:0] rd;
    s0 = start_cnt;
    apb_write(20'h0, 32'h1);
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1 || core_ctrl !== 2'd1 || core_noise !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL decode_launch: got start=%b ctrl=%0d noise=%h expected 1 1 deadbeef",
               core_start, core_ctrl, core_noise);
    end
    apb_write(20'h0, 32'h2);
    core_valid = 1'b1; core_data_out = 32'h12; core_num_of_errors = 2'd2;
    wait_done(0, cyc, got);
    checks++;
    if (!got || data_out !== 32'h12 || num_of_errors !== 2'd2) begin
      errors++;
      $display("FAIL decode_result: got done=%0b %h/%0d expected 1 00000012/2", got, data_out, num_of_errors);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL busy_relaunch: got %0d starts expected 1", start_cnt - s0);
    end
    apb_read(20'h0, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL busy_ctrl_readback: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit got;
    apb_write(20'h0, 32'h0);
    wait_done(0, cyc, got);
    checks++;
    if (!got || cyc != 10) begin
      errors++;
      $display("FAIL timeout_latency: got done=%0b after %0d cycles, expected done after 10", got, cyc);
    end
    checks++;
    if (num_of_errors !== 2'd3 || data_out !== 32'h12) begin
      errors++;
      $display("FAIL timeout_result: got %h/%0d expected 00000012/3", data_out, num_of_errors);
    end
  endtask

  task automatic test_valid_at_timeout();
    int cyc;
    bit got;
    apb_write(20'h0, 32'h0);
    repeat (8) @(negedge clk);
    core_valid = 1'b1; core_data_out = 32'h55; core_num_of_errors = 2'd1;
    wait_done(8, cyc, got);
    checks++;
    if (!got || cyc != 10 || data_out !== 32'h55 || num_of_errors !== 2'd1) begin
      errors++;
      $display("FAIL valid_at_timeout: got done=%0b cyc=%0d %h/%0d expected 1 10 00000055/1",
               got, cyc, data_out, num_of_errors);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit got;
    int d0;
    logic [31:0] rd;
    apb_write(20'h8, 32'h2);
    d0 = done_cnt;
    apb_write(20'h0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_valid = 1'b1; core_data_out = 32'h77; core_num_of_errors = 2'd1;
    @(negedge clk);
    core_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses expected 0", done_cnt - d0);
    end
    checks++;
    if (data_out !== '0 || num_of_errors !== 2'd0 || core_ctrl !== 2'd0 || core_width !== 2'd0 ||
        core_noise !== '0 || core_data_in !== '0 || operation_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got data_out=%h err=%0d ctrl=%0d width=%0d noise=%h din=%h done=%b expected all 0",
               data_out, num_of_errors, core_ctrl, core_width, core_noise, core_data_in, operation_done);
    end
    apb_read(20'h8, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL abort_width_reg: got %h expected 00000000", rd);
    end
    apb_write(20'h4, 32'h5A);
    apb_write(20'h8, 32'h1);
    apb_write(20'h0, 32'h2);
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1 || core_ctrl !== 2'd2 || core_width !== 2'd1 || core_data_in !== 32'h5A) begin
      errors++;
      $display("FAIL post_reset_launch: got start=%b ctrl=%0d width=%0d din=%h expected 1 2 1 0000005a",
               core_start, core_ctrl, core_width, core_data_in);
    end
    @(negedge clk);
    core_valid = 1'b1; core_data_out = 32'hABCD; core_num_of_errors = 2'd1;
    wait_done(2, cyc, got);
    checks++;
    if (!got || cyc != 4 || data_out !== 32'hABCD || num_of_errors !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_op: got done=%0b cyc=%0d %h/%0d expected 1 4 0000abcd/1",
               got, cyc, data_out, num_of_errors);
    end
  endtask

  initial begin
    rst = 1'b1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    core_valid = 1'b0; core_data_out = '0; core_num_of_errors = '0;
    test_reset();
    test_encode();
    test_readback();
    test_decode_busy();
    test_timeout();
    test_valid_at_timeout();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
